// File: rtl/seq_110110_moore_detector.sv
// seq_110110_moore_detector
// Moore FSM that flags the serial pattern 110110 on x (oldest bit first),
// overlapping matches included. y is high for the cycle the FSM sits in the
// match state.
// Optional build macro: SEQ_DET_COUNT_EN adds an 8-bit saturating match
// counter on port count. Without it, count and its logic are absent.
module seq_110110_moore_detector (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       x,
    output logic       y
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [7:0] count
`endif
);

    // State n holds the longest matched prefix of length n; S6 is the full match.
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6
    } state_t;

    state_t state_q, state_d;
    logic   y_q;

    // Next-state logic: on a mismatch, fall back to the longest suffix that is still a prefix.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = x ? S1 : S0;
            S1:      state_d = x ? S2 : S0;
            S2:      state_d = x ? S2 : S3;
            S3:      state_d = x ? S4 : S0;
            S4:      state_d = x ? S5 : S0;
            S5:      state_d = x ? S2 : S6;
            S6:      state_d = x ? S4 : S0;   // keep trailing 1101 for overlap
            default: state_d = S0;            // unused encoding 7 recovers to idle
        endcase
    end

`ifdef SEQ_DET_COUNT_EN
    logic [7:0] count_q;

    // State, registered detect flag and saturating match counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S0;
            y_q     <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            y_q     <= (state_d == S6);
            if (state_d == S6 && count_q != 8'hFF)
                count_q <= count_q + 8'd1;
        end
    end

    assign count = count_q;
`else
    // State and registered detect flag; y mirrors "state is S6" with no path from x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= (state_d == S6);
        end
    end
`endif

    assign y = y_q;

endmodule

// File: tb/tb_seq_110110_moore_detector.sv
// Testbench for seq_110110_moore_detector. Reference model keeps the last six
// sampled bits and the number of bits seen since reset; a match is simply
// "at least six bits seen and the window equals 110110".
module tb_seq_110110_moore_detector;

    logic       clk;
    logic       rst_n;
    logic       x;
    logic       y;
`ifdef SEQ_DET_COUNT_EN
    logic [7:0] count;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [5:0] hist;
    int         nbits;
    int         mcnt;      // saturating match count since reset

    seq_110110_moore_detector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y)
`ifdef SEQ_DET_COUNT_EN
        ,
        .count (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_y();
        return (nbits >= 6) && (hist == 6'b110110);
    endfunction

    task automatic model_reset();
        hist  = 6'd0;
        nbits = 0;
        mcnt  = 0;
    endtask

    // Drive one bit at the falling edge, let the rising edge sample it, settle 1ns.
    task automatic drive_bit(input logic b);
        @(negedge clk);
        x = b;
        @(posedge clk);
        hist  = {hist[4:0], b};
        nbits = nbits + 1;
        if (exp_y() && mcnt < 255) mcnt = mcnt + 1;
        #1;
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        x     = 1'b0;
        model_reset();
        #12;
        checks++;
        if (y !== 1'b0) begin errors++; $display("FAIL reset_y: got %b want 0", y); end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
`endif
        rst_n = 1'b1;
        // reach the match state, then reset asynchronously in mid-cycle
        foreach (hist[i]) drive_bit(1'b0);
        model_reset();
        begin
            logic [5:0] pat;
            pat = 6'b110110;
            for (int i = 5; i >= 0; i--) drive_bit(pat[i]);
        end
        checks++;
        if (y !== 1'b1) begin errors++; $display("FAIL pre_async_y: got %b want 1", y); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 1'b0) begin errors++; $display("FAIL async_reset_y: got %b want 0", y); end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if (count !== 8'd0) begin errors++; $display("FAIL async_reset_count: got %0d want 0", count); end
`endif
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_overlap_stream();
        logic [19:0] s;
        int          npulse;
        s = 20'b0001_1011_0110_0110_1110;
        npulse = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            logic want;
            drive_bit(s[19-i]);
            want = (i == 8 || i == 11);
            if (y === 1'b1) npulse++;
            checks++;
            if (y !== want || y !== exp_y()) begin
                errors++;
                $display("FAIL overlap_bit%0d: got %b want %b", i + 1, y, want);
            end
        end
        checks++;
        if (npulse != 2) begin errors++; $display("FAIL overlap_pulses: got %0d want 2", npulse); end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if (count !== 8'd2) begin errors++; $display("FAIL overlap_count: got %0d want 2", count); end
`endif
    endtask

    task automatic test_non_match();
        logic [8:0] s;
        s = 9'b110101100;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive_bit(s[8-i]);
            checks++;
            if (y !== 1'b0) begin errors++; $display("FAIL nonmatch_bit%0d: got %b want 0", i + 1, y); end
        end
        // after the final 0 the FSM is idle: 11011 alone must not finish a match
        begin
            logic [4:0] p;
            p = 5'b11011;
            for (int i = 4; i >= 0; i--) drive_bit(p[i]);
        end
        checks++;
        if (y !== 1'b0) begin errors++; $display("FAIL nonmatch_idle: got %b want 0", y); end
        drive_bit(1'b0);
        checks++;
        if (y !== 1'b1) begin errors++; $display("FAIL nonmatch_then_match: got %b want 1", y); end
    endtask

    task automatic test_chained();
        logic [11:0] s;
        int          npulse;
        s = 12'b110110110110;
        npulse = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            logic want;
            drive_bit(s[11-i]);
            want = (i == 5 || i == 8 || i == 11);
            if (y === 1'b1) npulse++;
            checks++;
            if (y !== want) begin errors++; $display("FAIL chained_bit%0d: got %b want %b", i + 1, y, want); end
        end
        checks++;
        if (npulse != 3) begin errors++; $display("FAIL chained_pulses: got %0d want 3", npulse); end
    endtask

    task automatic test_mid_reset();
        logic [4:0] p;
        logic [5:0] m;
        int         npulse;
        p = 5'b11011;
        m = 6'b110110;
        npulse = 0;
        do_reset();
        for (int i = 4; i >= 0; i--) drive_bit(p[i]);
        do_reset();
        drive_bit(1'b0);
        checks++;
        if (y !== 1'b0) begin errors++; $display("FAIL midreset_y: got %b want 0", y); end
        for (int i = 5; i >= 0; i--) begin
            drive_bit(m[i]);
            if (y === 1'b1) npulse++;
        end
        checks++;
        if (npulse != 1 || y !== 1'b1) begin
            errors++;
            $display("FAIL midreset_fresh: got pulses=%0d y=%b want pulses=1 y=1", npulse, y);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            // bias toward 1s so matches are frequent
            drive_bit(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
            if (y !== exp_y()) begin
                bad++;
                if (bad <= 5) $display("FAIL random_bit%0d: got %b want %b", i, y, exp_y());
            end
`ifdef SEQ_DET_COUNT_EN
            if (count !== mcnt[7:0]) begin
                bad++;
                if (bad <= 5) $display("FAIL random_count%0d: got %0d want %0d", i, count, mcnt);
            end
`endif
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL random_summary: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_saturation();
        int bad;
        int npulse;
        bad = 0;
        npulse = 0;
        do_reset();
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        // each further 110 closes another overlapping match
        for (int k = 0; k < 300; k++) begin
            drive_bit(1'b1);
            drive_bit(1'b1);
            drive_bit(1'b0);
            if (y === 1'b1) npulse++;
            if (y !== 1'b1 || y !== exp_y()) bad++;
        end
        checks++;
        if (bad != 0 || npulse != 300) begin
            errors++;
            $display("FAIL sat_pulses: got pulses=%0d bad=%0d want pulses=300 bad=0", npulse, bad);
        end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if (count !== 8'd255) begin errors++; $display("FAIL sat_count: got %0d want 255", count); end
`endif
    endtask

    initial begin
        test_reset();
        test_overlap_stream();
        test_non_match();
        test_chained();
        test_mid_reset();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
